uart_8bytes_rx: RTL and testbench
=================================

Name: uart_8bytes_rx

Overview:
Receive-side counterpart to the team's 8-byte RS-485 UART transmitter. It deserialises the transmitter's burst of 8 bytes into one frame. Each byte is 1 start bit, 8 data bits LSB first, 1 stop bit, then at least one idle bit-time. The block oversamples the line, assembles bytes into a staging buffer and presents the completed frame to downstream logic with a one-cycle strobe. It sits behind the RS-485 receiver pin of the acquiring board.

Parameters:
OVS, 4, clk cycles per bit-time; legal values are 3 or more.
NBYTES, 8, bytes per frame (byte index width = clog2(NBYTES)).
GAP_BITS, 16, idle bit-times after which a partial frame is aborted.

Ports:
clk  in  1  system clock, OVS x bit rate
reset  in  1  synchronous, active-low
rx  in  1  asynchronous serial line from RS-485 transceiver; idle high through failsafe bias
frame  out  8*NBYTES  last complete frame; byte k occupies bits [8k+7:8k]
frame_valid  out  1  one-cycle pulse; frame updated on the same cycle
byte_data  out  8  most recent received byte
byte_valid  out  1  one-cycle pulse per accepted byte
byte_idx  out  clog2(NBYTES)  slot of byte_data within the current frame
frame_err  out  1  one-cycle pulse; stop bit sampled low
gap_abort  out  1  one-cycle pulse; partial frame discarded after idle gap
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, while reset=0 at posedge clk:
  - state=IDLE.
  - All counters cleared and the byte index cleared.
  - frame, staging buffer and byte_data cleared to 0.
  - All pulse outputs 0; busy=0.
  - The rx synchroniser is preset to 1.
  - Reset asserted mid-byte or mid-frame discards everything with no error pulse.
- rx passes through a 2-FF synchroniser (rxs). All decisions use rxs, so there is 2 cycles of input latency.
- State machine:
  - IDLE: on a 1->0 transition of rxs, go to START with cnt=0.
  - START: count to OVS/2 (integer division), then resample rxs.
    - rxs=1: false start; return to IDLE with no pulse.
    - rxs=0: go to DATA with cnt=0 and bit=0.
  - DATA: every OVS cycles sample rxs into shift[bit], LSB first. After bit 7, go to STOP.
  - STOP: after OVS cycles sample rxs.
    - rxs=1: byte accepted.
      - byte_data<=shift, byte_idx<=idx, byte_valid=1, and staging[idx] is written.
      - If idx==NBYTES-1: frame<=staging with the new byte merged, frame_valid=1 on the same cycle as byte_valid, idx<=0.
      - Otherwise idx<=idx+1.
      - Next state IDLE.
    - rxs=0: frame_err=1, idx<=0, staging is not copied, go to BREAK.
  - BREAK: wait until rxs=1 for one full bit-time (OVS consecutive high samples), then go to IDLE. No start detection happens in this state.
- Latency: byte_valid and frame_valid assert 1 cycle after the stop-bit sample. That is about (9.5*OVS)+3 cycles after the start edge reaches the rx pin.
- Gap timer (IDLE only):
  - Counts consecutive rxs=1 cycles. It saturates at GAP_BITS*OVS and clears on any low sample or on leaving IDLE.
  - When the count reaches GAP_BITS*OVS and idx!=0: gap_abort=1 for one cycle and idx<=0.
  - When idx==0 the timer has no effect.
- frame holds its value between frame_valid pulses. A partial or aborted frame never alters frame.
- Byte index wraps modulo NBYTES only through frame completion, never by overflow.
- frame_err and gap_abort cannot occur on the same cycle, because they are raised from different states.
- A start edge arriving on the same cycle that the gap timer would expire takes priority: the abort is suppressed because the timer clears on the low sample.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK), shared with the transmitter's localparams;
  - the constants DATA_BITS=8 and UART_NBYTES=8.
- One natural sub-module, uart_bit_sampler: the 2-FF synchroniser plus falling-edge detect and the OVS bit-timing counter. It outputs rxs, fall and a sample strobe.
- Frame assembly and the gap timer stay in the top module.

Test Plan:
- Frame order: send 8 bytes 0x01,0x02,...,0x80 with 1 idle bit between bytes (OVS=4) -> 8 byte_valid pulses with byte_idx 0..7, one frame_valid, frame=64'h8040_2010_0804_0201.
- False start: 1-cycle low glitch on rx while in IDLE -> back to IDLE, no pulses, busy high for at most OVS/2+1 cycles.
- Bad stop bit: byte 0xA5 with stop bit driven 0 for 3 bit-times, then line idle -> frame_err pulse, idx=0, no byte_valid; the next clean 8-byte frame is received correctly.
- Partial frame: send 3 bytes, idle 16 bit-times -> gap_abort at exactly 64 idle cycles; frame keeps its previous value; the next frame starts at byte_idx 0.
- Back-to-back frames: two frames with no extra gap (11 bit-times per byte) -> two frame_valid pulses and correct contents for each.
- Reset mid-byte: assert reset during DATA bit 4 -> all outputs 0 the cycle after; the next frame is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and framing constants used by the
// 8-byte transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned UART_NBYTES = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-FF synchroniser, falling-edge detect and the bit-timing
// counter that raises sample at mid-bit (half) or once per bit-time.
module uart_bit_sampler #(
    parameter int unsigned OVS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic restart,
    input  logic half,
    output logic rxs,
    output logic fall,
    output logic sample
);

    localparam int unsigned CW = $clog2(OVS);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        sample = (cnt_q == (half ? HALF_LAST : FULL_LAST));
        cnt_d  = cnt_q + CW'(1);
        if (restart || sample) begin
            cnt_d = '0;
        end
    end

    assign rxs  = sync2_q;
    assign fall = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_8bytes_rx.sv
// Receives 8-byte UART bursts, assembles them into a frame and flags stop-bit
// errors and frames abandoned by an idle gap.
module uart_8bytes_rx import uart_pkg::*; #(
    parameter int unsigned OVS      = 4,
    parameter int unsigned NBYTES   = UART_NBYTES,
    parameter int unsigned GAP_BITS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [8*NBYTES-1:0]         frame,
    output logic                        frame_valid,
    output logic [7:0]                  byte_data,
    output logic                        byte_valid,
    output logic [$clog2(NBYTES)-1:0]   byte_idx,
    output logic                        frame_err,
    output logic                        gap_abort,
    output logic                        busy
);

    localparam int unsigned IW        = $clog2(NBYTES);
    localparam int unsigned BW        = $clog2(DATA_BITS);
    localparam int unsigned GAP_LIMIT = GAP_BITS * OVS;
    localparam int unsigned GW        = $clog2(GAP_LIMIT + 1);

    uart_state_e                  state_q, state_d;
    logic [BW-1:0]                bit_q, bit_d;
    logic [DATA_BITS-1:0]         shift_q, shift_d;
    logic [IW-1:0]                idx_q, idx_d, byte_idx_q, byte_idx_d;
    logic [NBYTES-1:0][7:0]       staging_q, staging_d, frame_q, frame_d, merged;
    logic [7:0]                   byte_data_q, byte_data_d;
    logic [GW-1:0]                gap_cnt_q, gap_cnt_d;
    logic                         byte_valid_q, byte_valid_d, frame_valid_q, frame_valid_d;
    logic                         frame_err_q, frame_err_d, gap_abort_q, gap_abort_d;
    logic                         rxs, fall, sample, restart, half;

    uart_bit_sampler #(
        .OVS (OVS)
    ) u_sampler (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .restart (restart),
        .half    (half),
        .rxs     (rxs),
        .fall    (fall),
        .sample  (sample)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            bit_q         <= '0;
            shift_q       <= '0;
            idx_q         <= '0;
            byte_idx_q    <= '0;
            staging_q     <= '0;
            frame_q       <= '0;
            byte_data_q   <= '0;
            gap_cnt_q     <= '0;
            byte_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            gap_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            byte_idx_q    <= byte_idx_d;
            staging_q     <= staging_d;
            frame_q       <= frame_d;
            byte_data_q   <= byte_data_d;
            gap_cnt_q     <= gap_cnt_d;
            byte_valid_q  <= byte_valid_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            gap_abort_q   <= gap_abort_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        byte_idx_d    = byte_idx_q;
        staging_d     = staging_q;
        frame_d       = frame_q;
        byte_data_d   = byte_data_q;
        gap_cnt_d     = '0;
        byte_valid_d  = 1'b0;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        gap_abort_d   = 1'b0;
        restart       = 1'b0;
        half          = 1'b0;
        merged        = staging_q;
        merged[idx_q] = shift_q;

        case (state_q)
            StIdle: begin
                restart = 1'b1;
                // A low sample clears the timer, so a start edge always beats the abort.
                if (rxs) begin
                    gap_cnt_d = (gap_cnt_q == GW'(GAP_LIMIT)) ? gap_cnt_q : gap_cnt_q + GW'(1);
                    if (gap_cnt_q == GW'(GAP_LIMIT - 1) && idx_q != '0) begin
                        gap_abort_d = 1'b1;
                        idx_d       = '0;
                    end
                end
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                half = 1'b1;
                if (sample) begin
                    state_d = rxs ? StIdle : StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (sample) begin
                    shift_d[bit_q] = rxs;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            StStop: begin
                if (sample) begin
                    if (rxs) begin
                        byte_data_d  = shift_q;
                        byte_idx_d   = idx_q;
                        byte_valid_d = 1'b1;
                        staging_d    = merged;
                        state_d      = StIdle;
                        if (idx_q == IW'(NBYTES - 1)) begin
                            frame_d       = merged;
                            frame_valid_d = 1'b1;
                            idx_d         = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Counter only survives a full bit-time of consecutive highs.
                restart = ~rxs;
                if (sample && rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign byte_idx    = byte_idx_q;
    assign frame_err   = frame_err_q;
    assign gap_abort   = gap_abort_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_8bytes_rx.sv
// Randomised bench for uart_8bytes_rx: drives serial bytes on rx and checks
// decoded bytes, frames and error pulses against a frame-level model.
module tb_uart_8bytes_rx;

    localparam int OVS = 4;
    localparam int NB  = 8;
    localparam int GAP = 16;
    localparam int IW  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic [63:0]   frame;
    logic          frame_valid, byte_valid, frame_err, gap_abort, busy;
    logic [7:0]    byte_data;
    logic [IW-1:0] byte_idx;

    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [63:0]   model_frame = '0;

    logic [7:0]    bv_data[$];
    logic [IW-1:0] bv_idx[$];
    int            bv_cyc[$];
    logic [63:0]   fv_q[$];
    int            err_cnt = 0;
    int            ab_cnt = 0;
    int            ab_cyc = 0;

    uart_8bytes_rx #(
        .OVS      (OVS),
        .NBYTES   (NB),
        .GAP_BITS (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .frame       (frame),
        .frame_valid (frame_valid),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_idx    (byte_idx),
        .frame_err   (frame_err),
        .gap_abort   (gap_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_data.push_back(byte_data);
            bv_idx.push_back(byte_idx);
            bv_cyc.push_back(cyc);
        end
        if (frame_valid) fv_q.push_back(frame);
        if (frame_err) err_cnt <= err_cnt + 1;
        if (gap_abort) begin
            ab_cnt <= ab_cnt + 1;
            ab_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // stop_low > 0 holds the stop bit low for that many bit-times.
    task automatic send_byte(input logic [7:0] d, input int stop_low, input int idle_bits);
        rx = 1'b0;
        tick(OVS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(OVS);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            tick(stop_low * OVS);
        end else begin
            rx = 1'b1;
            tick(OVS);
        end
        rx = 1'b1;
        tick(idle_bits * OVS);
    endtask

    task automatic send_frame(output logic [63:0] exp);
        logic [7:0] b;
        for (int k = 0; k < NB; k++) begin
            b = 8'($urandom_range(0, 255));
            exp[8*k +: 8] = b;
            send_byte(b, 0, 1);
        end
        tick(2 * OVS);
        model_frame = exp;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        tick(5);
        @(negedge clk);
        n_tests++;
        if ({frame_valid, byte_valid, frame_err, gap_abort, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b required 00000",
                     {frame_valid, byte_valid, frame_err, gap_abort, busy});
        end
        n_tests++;
        if (frame !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_frame: got %h required 0", frame);
        end
        n_tests++;
        if (byte_data !== 8'h0 || byte_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_byte: got %h/%0d required 0/0", byte_data, byte_idx);
        end
        reset = 1'b1;
        tick(2 * OVS);
    endtask

    task automatic test_frame_order();
        int b0 = bv_data.size();
        int f0 = fv_q.size();
        for (int k = 0; k < NB; k++) send_byte(8'(1 << k), 0, 1);
        tick(2 * OVS);
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (bv_data.size() <= b0 + k || bv_data[b0+k] !== 8'(1 << k)
                || bv_idx[b0+k] !== IW'(k)) begin
                n_fail++;
                $display("FAIL order_byte%0d: got %h/%0d required %h/%0d", k,
                         bv_data[b0+k], bv_idx[b0+k], 8'(1 << k), k);
            end
        end
        n_tests++;
        if (fv_q.size() - f0 != 1) begin
            n_fail++;
            $display("FAIL order_frame_count: got %0d required 1", fv_q.size() - f0);
        end
        n_tests++;
        if (frame !== 64'h8040_2010_0804_0201) begin
            n_fail++;
            $display("FAIL order_frame: got %h required 8040201008040201", frame);
        end
        model_frame = 64'h8040_2010_0804_0201;
    endtask

    task automatic test_false_start();
        int b0 = bv_data.size();
        int e0 = err_cnt;
        int busy_cnt = 0;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        for (int i = 0; i < 6 * OVS; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        n_tests++;
        if (busy_cnt < 1 || busy_cnt > OVS / 2 + 1) begin
            n_fail++;
            $display("FAIL false_start_busy: got %0d cycles required 1..%0d", busy_cnt,
                     OVS / 2 + 1);
        end
        n_tests++;
        if (bv_data.size() != b0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL false_start_pulses: got %0d bytes %0d errs required 0/0",
                     bv_data.size() - b0, err_cnt - e0);
        end
        tick(1);
    endtask

    task automatic test_bad_stop();
        logic [63:0] exp;
        int b0, f0;
        int e0 = err_cnt;
        send_byte(8'($urandom_range(0, 255)), 0, 1);
        send_byte(8'($urandom_range(0, 255)), 0, 1);
        b0 = bv_data.size();
        send_byte(8'hA5, 3, 2);
        n_tests++;
        if (err_cnt - e0 != 1 || bv_data.size() != b0) begin
            n_fail++;
            $display("FAIL bad_stop: got %0d errs %0d bytes required 1/0", err_cnt - e0,
                     bv_data.size() - b0);
        end
        f0 = fv_q.size();
        send_frame(exp);
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (bv_data.size() <= b0 + k || bv_data[b0+k] !== exp[8*k +: 8]
                || bv_idx[b0+k] !== IW'(k)) begin
                n_fail++;
                $display("FAIL bad_stop_next%0d: got %h/%0d required %h/%0d", k,
                         bv_data[b0+k], bv_idx[b0+k], exp[8*k +: 8], k);
            end
        end
        n_tests++;
        if (fv_q.size() - f0 != 1 || frame !== exp) begin
            n_fail++;
            $display("FAIL bad_stop_frame: got %h required %h", frame, exp);
        end
    endtask

    task automatic test_partial();
        logic [63:0] exp;
        int a0 = ab_cnt;
        int f0 = fv_q.size();
        int b0;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 0, 1);
        tick((GAP + 4) * OVS);
        n_tests++;
        if (ab_cnt - a0 != 1) begin
            n_fail++;
            $display("FAIL partial_abort_count: got %0d required 1", ab_cnt - a0);
        end
        n_tests++;
        if (ab_cyc - bv_cyc[bv_cyc.size()-1] != GAP * OVS) begin
            n_fail++;
            $display("FAIL partial_abort_time: got %0d idle cycles required %0d",
                     ab_cyc - bv_cyc[bv_cyc.size()-1], GAP * OVS);
        end
        n_tests++;
        if (fv_q.size() != f0 || frame !== model_frame) begin
            n_fail++;
            $display("FAIL partial_frame_hold: got %h required %h", frame, model_frame);
        end
        b0 = bv_data.size();
        send_frame(exp);
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (bv_data.size() <= b0 + k || bv_data[b0+k] !== exp[8*k +: 8]
                || bv_idx[b0+k] !== IW'(k)) begin
                n_fail++;
                $display("FAIL partial_next%0d: got %h/%0d required %h/%0d", k,
                         bv_data[b0+k], bv_idx[b0+k], exp[8*k +: 8], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp0, exp1;
        logic [7:0]  b;
        int f0 = fv_q.size();
        for (int k = 0; k < NB; k++) begin
            b = 8'($urandom_range(0, 255));
            exp0[8*k +: 8] = b;
            send_byte(b, 0, 1);
        end
        send_frame(exp1);
        n_tests++;
        if (fv_q.size() - f0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames required 2", fv_q.size() - f0);
        end else begin
            n_tests++;
            if (fv_q[f0] !== exp0) begin
                n_fail++;
                $display("FAIL b2b_frame0: got %h required %h", fv_q[f0], exp0);
            end
            n_tests++;
            if (fv_q[f0+1] !== exp1) begin
                n_fail++;
                $display("FAIL b2b_frame1: got %h required %h", fv_q[f0+1], exp1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        logic [7:0]  d = 8'($urandom_range(1, 255));
        int b0;
        send_byte(8'($urandom_range(1, 255)), 0, 1);
        rx = 1'b0;
        tick(OVS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            tick(OVS);
        end
        rx = d[4];
        tick(3);
        reset = 1'b0;
        tick(1);
        @(negedge clk);
        n_tests++;
        if ({frame_valid, byte_valid, frame_err, gap_abort, busy} !== 5'b0
            || frame !== 64'h0 || byte_data !== 8'h0 || byte_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got pulses %b frame %h byte %h/%0d required all 0",
                     {frame_valid, byte_valid, frame_err, gap_abort, busy}, frame,
                     byte_data, byte_idx);
        end
        rx = 1'b1;
        reset = 1'b1;
        tick(2 * OVS);
        model_frame = '0;
        b0 = bv_data.size();
        send_frame(exp);
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (bv_data.size() <= b0 + k || bv_data[b0+k] !== exp[8*k +: 8]
                || bv_idx[b0+k] !== IW'(k)) begin
                n_fail++;
                $display("FAIL reset_mid_next%0d: got %h/%0d required %h/%0d", k,
                         bv_data[b0+k], bv_idx[b0+k], exp[8*k +: 8], k);
            end
        end
        n_tests++;
        if (frame !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h required %h", frame, exp);
        end
    endtask

    initial begin
        test_reset();
        test_frame_order();
        test_false_start();
        test_bad_stop();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
